// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch request/response, data request/response,
// and the single memory port.
//   slave  : arbiter view (takes requests, drives responses and the memory port)
//   master : environment view (requesters plus memory model)
// Ports follow the arbiter's signal names: if_req_*/if_resp_*, d_req_*/d_resp_*, mem_*.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   // fetch requester
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_resp_valid;
   logic [DW-1:0] if_resp_data;
   logic          if_resp_err;
   // data requester
   logic          d_req_valid;
   logic          d_req_we;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata;
   logic          d_req_ready;
   logic          d_resp_valid;
   logic [DW-1:0] d_resp_data;
   logic          d_resp_err;
   // memory port
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the MEM-stage data requester. One access at a time: accept in IDLE, hold the
// memory port in BUSY until mem_ack or timeout, pulse a one-cycle response in RESP.
// Ports:
//   clock, reset  single clock, synchronous active-high reset
//   bus           mem_port_arbiter_if.slave (requests, responses, memory port)
// Parameters: AW address width, DW data width, TIMEOUT max mem_en cycles without ack.
// Optional build macro ARB_ROUND_ROBIN_EN: on contention, grant alternates away from
// the last winner; otherwise data always beats fetch.
module mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   localparam int unsigned CW  = 8;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          owner_d;     // 1 = data requester owns the access in flight
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          if_resp_valid;
   logic [DW-1:0] if_resp_data;
   logic          if_resp_err;
   logic          d_resp_valid;
   logic [DW-1:0] d_resp_data;
   logic          d_resp_err;

   logic          d_ready_c;
   logic          if_ready_c;
   logic          grant_d_c;
   logic          grant_if_c;
   logic [CW-1:0] cnt_inc_c;
   logic          done_c;
   logic [DW-1:0] rdata_c;

`ifdef ARB_ROUND_ROBIN_EN
   logic          last_grant_d;   // 1 = data won the previous acceptance

   // On contention the requester that did not win last time is preferred.
   always_comb begin
      d_ready_c  = (state == IDLE) && !(bus.if_req_valid && last_grant_d);
      if_ready_c = (state == IDLE) && !(bus.d_req_valid && !last_grant_d);
   end
`else
   // Data beats fetch: the MEM-stage instruction is older.
   always_comb begin
      d_ready_c  = (state == IDLE);
      if_ready_c = (state == IDLE) && !bus.d_req_valid;
   end
`endif

   // Acceptance strobes and BUSY completion terms.
   always_comb begin
      grant_d_c  = bus.d_req_valid && d_ready_c;
      grant_if_c = bus.if_req_valid && if_ready_c;
      cnt_inc_c  = (cnt == TMO) ? cnt : cnt + CW'(1);
      // An ack on the limit cycle still completes cleanly.
      done_c     = bus.mem_ack || (cnt_inc_c == TMO);
      rdata_c    = (bus.mem_ack && !mem_we) ? bus.mem_rdata : '0;
   end

   // Control FSM with registered memory-port and response outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         owner_d       <= 1'b0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         if_resp_valid <= 1'b0;
         if_resp_data  <= '0;
         if_resp_err   <= 1'b0;
         d_resp_valid  <= 1'b0;
         d_resp_data   <= '0;
         d_resp_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_d  <= 1'b0;
`endif
      end else begin
         // Response valids are single-cycle pulses.
         if_resp_valid <= 1'b0;
         d_resp_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d_c || grant_if_c) begin
                  state     <= BUSY;
                  cnt       <= '0;
                  owner_d   <= grant_d_c;
                  mem_en    <= 1'b1;
                  mem_we    <= grant_d_c && bus.d_req_we;
                  mem_addr  <= grant_d_c ? bus.d_req_addr : bus.if_req_addr;
                  mem_wdata <= grant_d_c ? bus.d_req_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant_d <= grant_d_c;
`endif
               end
            end
            BUSY: begin
               if (!bus.mem_ack) begin
                  cnt <= cnt_inc_c;
               end
               if (done_c) begin
                  state  <= RESP;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (owner_d) begin
                     d_resp_valid <= 1'b1;
                     d_resp_data  <= rdata_c;
                     d_resp_err   <= !bus.mem_ack;
                  end else begin
                     if_resp_valid <= 1'b1;
                     if_resp_data  <= rdata_c;
                     if_resp_err   <= !bus.mem_ack;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.d_req_ready   = d_ready_c;
   assign bus.if_req_ready  = if_ready_c;
   assign bus.mem_en        = mem_en;
   assign bus.mem_we        = mem_we;
   assign bus.mem_addr      = mem_addr;
   assign bus.mem_wdata     = mem_wdata;
   assign bus.if_resp_valid = if_resp_valid;
   assign bus.if_resp_data  = if_resp_data;
   assign bus.if_resp_err   = if_resp_err;
   assign bus.d_resp_valid  = d_resp_valid;
   assign bus.d_resp_data   = d_resp_data;
   assign bus.d_resp_err    = d_resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: random fetch/load/store traffic with a
// reference memory model, expected responses queued at acceptance and popped by a
// response monitor, plus a memory responder that checks the memory port.
module tb_mem_port_arbiter;

   localparam int unsigned AW      = 32;
   localparam int unsigned DW      = 32;
   localparam int unsigned TIMEOUT = 15;

   typedef struct {
      bit            is_d;
      logic [DW-1:0] data;
      bit            err;
   } resp_t;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            delay;   // ack on mem_en cycle delay+1; >= TIMEOUT means never
   } acc_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   resp_t         exp_q[$];
   acc_t          acc_q[$];
   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] ref_mem [64];   // reference model contents
   logic [DW-1:0] dev_mem [64];   // memory device contents
   bit            responder_on = 1'b1;
   bit            stray_ack = 1'b0;
   bit            last_d = 1'b0;  // model: data won the last acceptance
   int            force_delay = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic acc_t mk_req(input bit is_d);
      acc_t a;
      int   r;
      a.addr  = AW'({$urandom_range(0, 63), 2'b00});
      a.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a.wdata = a.we ? DW'($urandom) : '0;
      r = int'($urandom_range(0, 9));
      if (force_delay >= 0) a.delay = force_delay;
      else if (r <= 6)      a.delay = int'($urandom_range(0, 3));
      else if (r == 7)      a.delay = TIMEOUT - 1;
      else if (r == 8)      a.delay = TIMEOUT - 2;
      else                  a.delay = TIMEOUT + 5;
      return a;
   endfunction

   // Reference model: the response an accepted request must produce.
   task automatic model_accept(input acc_t a, input bit is_d);
      resp_t r;
      int    idx;
      idx    = int'(a.addr[7:2]);
      r.is_d = is_d;
      if (a.delay >= int'(TIMEOUT)) begin
         r.data = '0;
         r.err  = 1'b1;
      end else begin
         r.err  = 1'b0;
         r.data = a.we ? '0 : ref_mem[idx];
         if (a.we) ref_mem[idx] = a.wdata;
      end
      exp_q.push_back(r);
      acc_q.push_back(a);
      last_d = is_d;
   endtask

   // Random requesters: each port holds its request until accepted.
   task automatic run_random(input int n);
      int   issued = 0;
      int   guard  = 0;
      bit   dp = 1'b0;
      bit   ip = 1'b0;
      bit   d_acc, i_acc, pred_d;
      acc_t dreq, ireq;
      while ((issued < n || dp || ip) && guard < 20000) begin
         @(negedge clock);
         guard++;
         if (!dp && issued < n && $urandom_range(0, 2) == 0) begin
            dp = 1'b1; issued++; dreq = mk_req(1'b1);
         end
         if (!ip && issued < n && $urandom_range(0, 2) == 0) begin
            ip = 1'b1; issued++; ireq = mk_req(1'b0);
         end
         bus.d_req_valid  = dp;
         bus.d_req_we     = dreq.we;
         bus.d_req_addr   = dreq.addr;
         bus.d_req_wdata  = dreq.wdata;
         bus.if_req_valid = ip;
         bus.if_req_addr  = ireq.addr;
         #1;
         d_acc = dp && bus.d_req_ready;
         i_acc = ip && bus.if_req_ready;
         if (dp && ip && (d_acc || i_acc)) begin
`ifdef ARB_ROUND_ROBIN_EN
            pred_d = !last_d;
`else
            pred_d = 1'b1;
`endif
            check("arb_winner", {62'd0, d_acc, i_acc}, pred_d ? 64'd2 : 64'd1);
            d_acc = pred_d;
            i_acc = !pred_d;
         end
         if (d_acc) begin
            model_accept(dreq, 1'b1);
            dp = 1'b0;
         end else if (i_acc) begin
            model_accept(ireq, 1'b0);
            ip = 1'b0;
         end
      end
      check("issue_guard", {62'd0, dp, ip}, 64'd0);
      @(negedge clock);
      bus.d_req_valid  = 1'b0;
      bus.if_req_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || acc_q.size() != 0) && g < 200) begin
         @(negedge clock);
         g++;
      end
      check("drain_empty", 64'(exp_q.size() + acc_q.size()), 64'd0);
   endtask

   // Memory device: acks after the per-request delay and checks the held port.
   int   rcnt = 0;
   bit   ractive = 1'b0;
   acc_t cur;
   always @(negedge clock) begin
      if (!responder_on) begin
         bus.mem_ack   = stray_ack;
         bus.mem_rdata = DW'($urandom);
         ractive       = 1'b0;
         rcnt          = 0;
      end else begin
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = DW'($urandom);
         if (bus.mem_en) begin
            if (!ractive) begin
               if (acc_q.size() == 0) begin
                  fail("mem_en_without_accept");
                  cur.delay = TIMEOUT + 5;
                  cur.we    = bus.mem_we;
                  cur.addr  = bus.mem_addr;
                  cur.wdata = bus.mem_wdata;
               end else begin
                  cur = acc_q.pop_front();
               end
               ractive = 1'b1;
               rcnt    = 0;
            end
            rcnt++;
            check("mem_addr", 64'(bus.mem_addr), 64'(cur.addr));
            check("mem_we", 64'(bus.mem_we), 64'(cur.we));
            if (cur.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
            if (rcnt == cur.delay + 1) begin
               bus.mem_ack = 1'b1;
               if (cur.we) dev_mem[int'(cur.addr[7:2])] = cur.wdata;
               else        bus.mem_rdata = dev_mem[int'(cur.addr[7:2])];
            end
         end else if (ractive) begin
            check("mem_en_cycles", 64'(rcnt),
                  64'((cur.delay + 1 < int'(TIMEOUT)) ? cur.delay + 1 : int'(TIMEOUT)));
            ractive = 1'b0;
         end
      end
   end

   // Response monitor: pops the scoreboard on every response pulse.
   bit    chk_idle = 1'b0;
   resp_t e;
   always @(negedge clock) begin
      if (bus.d_resp_valid || bus.if_resp_valid) begin
         check("ready_in_resp", {62'd0, bus.d_req_ready, bus.if_req_ready}, 64'd0);
         if (bus.d_resp_valid && bus.if_resp_valid) fail("both_resp_valid");
         if (exp_q.size() == 0) begin
            fail("unexpected_resp");
         end else begin
            e = exp_q.pop_front();
            check("resp_port_d", 64'(bus.d_resp_valid), 64'(e.is_d));
            if (e.is_d) begin
               check("d_resp_data", 64'(bus.d_resp_data), 64'(e.data));
               check("d_resp_err", 64'(bus.d_resp_err), 64'(e.err));
            end else begin
               check("if_resp_data", 64'(bus.if_resp_data), 64'(e.data));
               check("if_resp_err", 64'(bus.if_resp_err), 64'(e.err));
            end
         end
         chk_idle = 1'b1;
      end else if (chk_idle) begin
         // Cycle after the pulse the arbiter is IDLE: some requester is ready.
         check("ready_after_resp", 64'(bus.d_req_ready || bus.if_req_ready), 64'd1);
         chk_idle = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = DW'($urandom);
         dev_mem[i] = ref_mem[i];
      end
      ref_mem[4] = 32'h0000_0013;
      dev_mem[4] = 32'h0000_0013;
      reset            = 1'b1;
      bus.d_req_valid  = 1'b0;
      bus.d_req_we     = 1'b0;
      bus.d_req_addr   = '0;
      bus.d_req_wdata  = '0;
      bus.if_req_valid = 1'b0;
      bus.if_req_addr  = '0;
      bus.mem_ack      = 1'b0;
      bus.mem_rdata    = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_d_resp_valid", 64'(bus.d_resp_valid), 64'd0);
      check("rst_if_resp_valid", 64'(bus.if_resp_valid), 64'd0);
      check("rst_d_req_ready", 64'(bus.d_req_ready), 64'd1);
      check("rst_if_req_ready", 64'(bus.if_req_ready), 64'd1);

      run_random(60);
      drain();

      // Ack exactly on the limit cycle, then a genuine timeout.
      force_delay = TIMEOUT - 1;
      run_random(2);
      drain();
      force_delay = TIMEOUT + 3;
      run_random(2);
      drain();
      force_delay = -1;

      // Reset while BUSY: no response, late ack ignored.
      responder_on = 1'b0;
      @(negedge clock);
      bus.d_req_valid = 1'b1;
      bus.d_req_we    = 1'b0;
      bus.d_req_addr  = 32'h20;
      @(negedge clock);
      bus.d_req_valid = 1'b0;
      check("dir_mem_en_up", 64'(bus.mem_en), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      stray_ack = 1'b1;
      last_d    = 1'b0;
      check("rst_busy_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_busy_resp", {62'd0, bus.d_resp_valid, bus.if_resp_valid}, 64'd0);
      @(negedge clock);
      stray_ack = 1'b0;
      check("stray_ack_mem_en", 64'(bus.mem_en), 64'd0);
      repeat (3) @(negedge clock);
      check("stray_ack_resp", {62'd0, bus.d_resp_valid, bus.if_resp_valid}, 64'd0);
      responder_on = 1'b1;
      run_random(6);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
